reg_mask_encoder: RTL and testbench

Sequential 32-to-5 register-index encoder: the inverse of the register-select decoder. Accepts a 32-bit register mask (one bit per architectural register) and emits the 5-bit index of every set bit, lowest first, one per handshake. Sits in the processor datapath ahead of the register file. Used wherever a multi-register mask must be serialised into register numbers: bulk save/restore, scoreboard release, multi-register writeback.

---
 rtl/reg_mask_encoder.sv | 129 ++++++++++++
 tb/tb_reg_mask_encoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_mask_encoder.sv
// reg_mask_encoder
// Serialises a 32-bit register mask into the 5-bit indices of its set bits,
// lowest first, one index per idx_valid/idx_ready handshake.
//
// Parameters:
//   SKIP_R0    - when nonzero, mask bit 0 is dropped at load (r0 is hardwired zero)
// Ports:
//   clock      - clock, rising edge
//   reset_n    - asynchronous active-low reset
//   load_valid - a new mask is offered
//   load_mask  - mask offered, bit i requests register i
//   load_ready - block can accept a mask (IDLE)
//   idx_valid  - idx_out/idx_onehot hold a valid index (SCAN)
//   idx_out    - index of lowest set bit of the remaining mask
//   idx_onehot - one-hot form of idx_out, zero when idx_valid=0
//   idx_ready  - consumer accepts idx_out this cycle
//   done       - one-cycle pulse after the mask has been fully emitted
//   busy       - high while scanning
//   count      - indices emitted for the current or most recent mask
module reg_mask_encoder #(
    parameter int unsigned SKIP_R0 = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        load_valid,
    input  logic [31:0] load_mask,
    output logic        load_ready,
    output logic        idx_valid,
    output logic [4:0]  idx_out,
    output logic [31:0] idx_onehot,
    input  logic        idx_ready,
    output logic        done,
    output logic        busy,
    output logic [5:0]  count
);

    localparam int unsigned MASK_W  = 32;
    localparam int unsigned IDX_W   = 5;
    localparam int unsigned COUNT_W = 6;

    // Bits kept from load_mask at load time.
    localparam logic [MASK_W-1:0] LOAD_KEEP =
        (SKIP_R0 != 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t              state;
    logic [MASK_W-1:0]   remaining;
    logic [COUNT_W-1:0]  count_q;
    logic                done_q;

    logic [MASK_W-1:0]   eff_mask_c;
    logic [MASK_W-1:0]   lowest_c;
    logic [MASK_W-1:0]   cleared_c;
    logic [IDX_W-1:0]    enc_c;
    logic                handshake_c;

    // Effective mask and lowest-set-bit isolation of the remaining mask.
    always_comb begin
        eff_mask_c  = load_mask & LOAD_KEEP;
        lowest_c    = remaining & (~remaining + MASK_W'(1));
        cleared_c   = remaining & ~lowest_c;
        handshake_c = (state == SCAN) && idx_ready;
    end

    // Priority encode: scanning downward lets the lowest set bit win.
    always_comb begin
        enc_c = '0;
        for (int i = MASK_W - 1; i >= 0; i--) begin
            if (remaining[i]) begin
                enc_c = IDX_W'(i);
            end
        end
    end

    // Control FSM plus the remaining-mask, count and done registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            remaining <= '0;
            count_q   <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        remaining <= eff_mask_c;
                        count_q   <= '0;
                        // An empty effective mask finishes without scanning.
                        if (eff_mask_c == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state <= SCAN;
                        end
                    end
                end
                SCAN: begin
                    if (handshake_c) begin
                        remaining <= cleared_c;
                        count_q   <= count_q + COUNT_W'(1);
                        if (cleared_c == '0) begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decodes of registered state only.
    always_comb begin
        load_ready = (state == IDLE);
        busy       = (state == SCAN);
        idx_valid  = (state == SCAN);
        idx_out    = (state == SCAN) ? enc_c : '0;
        idx_onehot = (state == SCAN) ? lowest_c : '0;
        done       = done_q;
        count      = count_q;
    end

endmodule

// File: tb/tb_reg_mask_encoder.sv
// tb_reg_mask_encoder
// Two instances (SKIP_R0=0 and SKIP_R0=1) share one stimulus stream. A queue
// model of pending indices per instance is checked every cycle, and directed
// tests pin the model with hand-computed values.
module tb_reg_mask_encoder;

    logic        clock      = 1'b0;
    logic        reset_n    = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_mask  = '0;
    logic        idx_ready  = 1'b0;

    logic [1:0]  lr;
    logic [1:0]  iv;
    logic [1:0]  dn;
    logic [1:0]  by;
    logic [4:0]  io [2];
    logic [31:0] oh [2];
    logic [5:0]  cn [2];

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Model: queue of indices still to emit, count and done per instance.
    int unsigned mq [2][$];
    int unsigned m_cnt [2];
    bit          m_done [2];

    always #5 clock = ~clock;

    reg_mask_encoder #(.SKIP_R0(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n),
        .load_valid(load_valid), .load_mask(load_mask), .load_ready(lr[0]),
        .idx_valid(iv[0]), .idx_out(io[0]), .idx_onehot(oh[0]),
        .idx_ready(idx_ready), .done(dn[0]), .busy(by[0]), .count(cn[0])
    );

    reg_mask_encoder #(.SKIP_R0(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .load_valid(load_valid), .load_mask(load_mask), .load_ready(lr[1]),
        .idx_valid(iv[1]), .idx_out(io[1]), .idx_onehot(oh[1]),
        .idx_ready(idx_ready), .done(dn[1]), .busy(by[1]), .count(cn[1])
    );

    task automatic chk(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h at %0t",
                     name, k, act, exp, $time);
        end
    endtask

    // Model update on the same edge the DUT samples.
    always @(posedge clock or negedge reset_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!reset_n) begin
                mq[k].delete();
                m_cnt[k]  = 0;
                m_done[k] = 1'b0;
            end else if (mq[k].size() == 0) begin
                m_done[k] = 1'b0;
                if (load_valid) begin
                    m_cnt[k] = 0;
                    for (int i = 0; i < 32; i++) begin
                        if (load_mask[i] && !(i == 0 && k == 1)) mq[k].push_back(i);
                    end
                    if (mq[k].size() == 0) m_done[k] = 1'b1;
                end
            end else begin
                m_done[k] = 1'b0;
                if (idx_ready) begin
                    void'(mq[k].pop_front());
                    m_cnt[k]++;
                    if (mq[k].size() == 0) m_done[k] = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model on the falling edge.
    always @(negedge clock) begin
        if (cmp_en) begin
            for (int k = 0; k < 2; k++) begin
                bit exp_v;
                exp_v = (mq[k].size() != 0);
                chk("m_idx_valid", k, 32'(iv[k]), 32'(exp_v));
                chk("m_busy", k, 32'(by[k]), 32'(exp_v));
                chk("m_load_ready", k, 32'(lr[k]), 32'(!exp_v));
                chk("m_done", k, 32'(dn[k]), 32'(m_done[k]));
                chk("m_count", k, 32'(cn[k]), m_cnt[k]);
                chk("m_onehot", k, oh[k], exp_v ? (32'(1) << mq[k][0]) : 32'h0);
                if (exp_v) chk("m_idx_out", k, 32'(io[k]), mq[k][0]);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        idx_ready = 1'b1;
        while (lr != 2'b11 && n < 200) begin
            step();
            n++;
        end
        chk("idle_timeout", 0, 32'(n < 200), 32'd1);
        step();
    endtask

    task automatic check_reset_values();
        for (int k = 0; k < 2; k++) begin
            chk("rst_idx_valid", k, 32'(iv[k]), 32'd0);
            chk("rst_idx_out", k, 32'(io[k]), 32'd0);
            chk("rst_onehot", k, oh[k], 32'd0);
            chk("rst_busy", k, 32'(by[k]), 32'd0);
            chk("rst_load_ready", k, 32'(lr[k]), 32'd1);
            chk("rst_done", k, 32'(dn[k]), 32'd0);
            chk("rst_count", k, 32'(cn[k]), 32'd0);
        end
    endtask

    // Bounded run with pseudo-random consumer stalls; model does the checking.
    task automatic run_mask(input logic [31:0] m);
        int n = 0;
        load_mask  = m;
        load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        while ((lr != 2'b11 || dn != 2'b00) && n < 300) begin
            idx_ready = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        chk("run_timeout", 0, 32'(n < 300), 32'd1);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while reset_n is held low.
        #12;
        check_reset_values();
        @(negedge clock);
        reset_n = 1'b1;
        step();
        cmp_en = 1'b1;

        // 0x12: indices 1 then 4, done third cycle, count 2.
        load_mask = 32'h0000_0012; load_valid = 1'b1; idx_ready = 1'b1;
        step();
        load_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("t1_idx1", k, 32'(io[k]), 32'd1);
            chk("t1_oh1", k, oh[k], 32'h2);
            chk("t1_valid", k, 32'(iv[k]), 32'd1);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t1_idx4", k, 32'(io[k]), 32'd4);
            chk("t1_oh4", k, oh[k], 32'h10);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t1_done", k, 32'(dn[k]), 32'd1);
            chk("t1_count", k, 32'(cn[k]), 32'd2);
            chk("t1_load_ready", k, 32'(lr[k]), 32'd1);
        end
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t1_done_pulse", k, 32'(dn[k]), 32'd0);
            chk("t1_count_hold", k, 32'(cn[k]), 32'd2);
        end

        // 0x1: inst1 ignores r0, inst0 emits index 0.
        load_mask = 32'h0000_0001; load_valid = 1'b1;
        step();
        load_valid = 1'b0;
        chk("t2_r0_done", 1, 32'(dn[1]), 32'd1);
        chk("t2_r0_valid", 1, 32'(iv[1]), 32'd0);
        chk("t2_r0_count", 1, 32'(cn[1]), 32'd0);
        chk("t2_idx0_valid", 0, 32'(iv[0]), 32'd1);
        chk("t2_idx0", 0, 32'(io[0]), 32'd0);
        chk("t2_oh0", 0, oh[0], 32'h1);
        step();
        chk("t2_done0", 0, 32'(dn[0]), 32'd1);
        chk("t2_count0", 0, 32'(cn[0]), 32'd1);
        chk("t2_done1_low", 1, 32'(dn[1]), 32'd0);
        step();

        // Full mask: 32 indices on inst0, 31 on inst1.
        load_mask = 32'hFFFF_FFFF; load_valid = 1'b1; idx_ready = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("t3_idx", 0, 32'(io[0]), 32'(i));
            if (i < 31) begin
                chk("t3_idx", 1, 32'(io[1]), 32'(i + 1));
            end else begin
                chk("t3_done", 1, 32'(dn[1]), 32'd1);
                chk("t3_count", 1, 32'(cn[1]), 32'd31);
            end
            step();
        end
        chk("t3_done", 0, 32'(dn[0]), 32'd1);
        chk("t3_count", 0, 32'(cn[0]), 32'd32);
        wait_idle();

        // 0x8000_0401 with idx_ready toggling 0/1/0/1.
        load_mask = 32'h8000_0401; load_valid = 1'b1; idx_ready = 1'b0;
        step();
        load_valid = 1'b0;
        chk("t4_stall_a", 1, 32'(io[1]), 32'd10);
        step();
        chk("t4_stall_b", 1, 32'(io[1]), 32'd10);
        idx_ready = 1'b1;
        step();
        chk("t4_idx31_a", 1, 32'(io[1]), 32'd31);
        idx_ready = 1'b0;
        step();
        chk("t4_idx31_b", 1, 32'(io[1]), 32'd31);
        chk("t4_inst0_idx10", 0, 32'(io[0]), 32'd10);
        idx_ready = 1'b1;
        step();
        chk("t4_done", 1, 32'(dn[1]), 32'd1);
        chk("t4_count", 1, 32'(cn[1]), 32'd2);
        chk("t4_inst0_idx31", 0, 32'(io[0]), 32'd31);
        step();
        chk("t4_done", 0, 32'(dn[0]), 32'd1);
        chk("t4_count", 0, 32'(cn[0]), 32'd3);
        wait_idle();

        // Load offered during SCAN waits, then is accepted after done.
        load_mask = 32'h0000_0006; load_valid = 1'b1; idx_ready = 1'b1;
        step();
        load_mask = 32'h0000_00F0;
        for (int k = 0; k < 2; k++) begin
            chk("t5_idx1", k, 32'(io[k]), 32'd1);
            chk("t5_busy_lr", k, 32'(lr[k]), 32'd0);
        end
        step();
        for (int k = 0; k < 2; k++) chk("t5_idx2", k, 32'(io[k]), 32'd2);
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t5_done", k, 32'(dn[k]), 32'd1);
            chk("t5_lr", k, 32'(lr[k]), 32'd1);
        end
        step();
        load_valid = 1'b0;
        for (int i = 4; i < 8; i++) begin
            for (int k = 0; k < 2; k++) chk("t5_pend_idx", k, 32'(io[k]), 32'(i));
            step();
        end
        for (int k = 0; k < 2; k++) begin
            chk("t5_pend_done", k, 32'(dn[k]), 32'd1);
            chk("t5_pend_count", k, 32'(cn[k]), 32'd4);
        end
        wait_idle();

        // Reset mid-SCAN after three handshakes.
        load_mask = 32'h0000_FF00; load_valid = 1'b1; idx_ready = 1'b1;
        step();
        load_valid = 1'b0;
        for (int i = 8; i < 12; i++) begin
            for (int k = 0; k < 2; k++) chk("t6_idx", k, 32'(io[k]), 32'(i));
            if (i < 11) step();
        end
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        step();
        step();
        #2;
        reset_n = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            chk("t6_no_done", k, 32'(dn[k]), 32'd0);
            chk("t6_lr", k, 32'(lr[k]), 32'd1);
            chk("t6_count", k, 32'(cn[k]), 32'd0);
        end
        step();
        for (int k = 0; k < 2; k++) chk("t6_no_done_late", k, 32'(dn[k]), 32'd0);

        // Further masks with random stalls, checked by the model.
        run_mask(32'h0000_0000);
        run_mask(32'h8000_0000);
        run_mask(32'hA5A5_A5A5);
        run_mask(32'h0000_0003);
        run_mask(32'h7FFF_FFFE);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
